// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data-first with a fetch-starvation bound.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DWELL_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  output logic              if_stall,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [3:0]        d_req_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [3:0]        mem_req_wmask,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);
  localparam int DW = $clog2(DWELL_MAX + 1);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic              grant_data, grant_fetch;
  // owner_q is 1 when the data side holds the port
  always_comb begin
    grant_data  = d_req_valid && !(if_req_valid && dwell_q == DW'(DWELL_MAX));
    grant_fetch = !grant_data && if_req_valid;
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    dwell_d     = dwell_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: if (grant_data || grant_fetch) begin
        state_d = REQ;
        owner_d = grant_data;
        addr_d  = grant_data ? d_addr : if_addr;
        we_d    = grant_data && d_req_we;
        wmask_d = grant_data ? d_req_wmask : '0;
        wdata_d = grant_data ? d_wdata : '0;
        dwell_d = !(grant_data && if_req_valid) ? '0 :
                  (dwell_q == DW'(DWELL_MAX)) ? dwell_q : dwell_q + 1'b1;
      end
      REQ: if (mem_req_ready) begin
        state_d = we_q ? RESP : WAIT;
        if (we_q) d_rdata_d = '0;
      end
      WAIT: if (mem_resp_valid) begin
        state_d = RESP;
        if (owner_q) d_rdata_d = mem_resp_data;
        else if_rdata_d = mem_resp_data;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      dwell_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      dwell_q    <= dwell_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  assign mem_req_valid = state_q == REQ;
  assign mem_req_we    = we_q;
  assign mem_req_wmask = wmask_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = wdata_q;
  assign if_resp_valid = state_q == RESP && !owner_q;
  assign d_resp_valid  = state_q == RESP && owner_q;
  assign if_resp_data  = if_rdata_q;
  assign d_resp_data   = d_rdata_q;
  assign if_stall      = if_req_valid && !if_resp_valid;
  assign d_stall       = d_req_valid && !d_resp_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory against a timestamped transaction model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, DMAX = 4, NCYC = 4000;
  logic clk = 1'b0, reset_n = 1'b0;
  logic if_req_valid = 1'b0, d_req_valid = 1'b0, d_req_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0, mem_req_addr;
  logic [DW-1:0] d_wdata = '0, if_resp_data, d_resp_data, mem_req_data, mem_resp_data = '0;
  logic [3:0] d_req_wmask = '0, mem_req_wmask;
  logic if_resp_valid, if_stall, d_resp_valid, d_stall, mem_req_valid, mem_req_we;
  logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DWELL_MAX(DMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_resp_valid(if_resp_valid),
    .if_resp_data(if_resp_data), .if_stall(if_stall),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_wmask(d_req_wmask),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data), .d_stall(d_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_wmask(mem_req_wmask), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  // transaction model: who owns the port, when its request is open, when its response is due
  bit f_act, d_act, busy, req_open, rd_pend, own_d, gd, ex_ifv, ex_dv, rst_done;
  int resp_due, resp_at, dwell, rst_left, p;
  logic [AW-1:0] x_addr;
  logic x_we;
  logic [3:0] x_mask;
  logic [DW-1:0] x_data, e_if_data, e_d_data;
  initial begin
    f_act = 0; d_act = 0; rst_done = 0; rst_left = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (!rst_done && cyc > 1000 && rd_pend && !own_d) begin
        rst_left = 2;
        rst_done = 1;
      end
      reset_n = !(cyc < 3 || rst_left > 0);
      if (rst_left > 0) rst_left--;
      if (!reset_n) begin
        busy = 0; req_open = 0; rd_pend = 0; resp_due = -1; dwell = 0;
        e_if_data = '0; e_d_data = '0; x_addr = '0; x_we = 0; x_mask = '0; x_data = '0;
      end
      p = (cyc < 2000) ? 2 : 4;
      if (!f_act) begin
        if_addr = AW'($urandom);
        if ($urandom_range(3) < p) f_act = 1;
      end
      if (!d_act) begin
        d_addr = AW'($urandom);
        d_req_we = 1'($urandom);
        d_req_wmask = 4'($urandom);
        d_wdata = DW'($urandom);
        if ($urandom_range(3) < p) d_act = 1;
      end
      if_req_valid = f_act;
      d_req_valid = d_act;
      mem_req_ready = ($urandom_range(2) != 0);
      mem_resp_data = DW'($urandom);
      mem_resp_valid = rd_pend ? (cyc == resp_at) : ($urandom_range(7) == 0);
      #1;
      ex_ifv = busy && cyc == resp_due && !own_d;
      ex_dv = busy && cyc == resp_due && own_d;
      check("mem_req_valid", 64'(mem_req_valid), 64'(req_open));
      if (req_open || !reset_n) begin
        check("mem_req_addr", 64'(mem_req_addr), 64'(x_addr));
        check("mem_req_we", 64'(mem_req_we), 64'(x_we));
        check("mem_req_wmask", 64'(mem_req_wmask), 64'(x_mask));
        check("mem_req_data", 64'(mem_req_data), 64'(x_data));
      end
      check("if_resp_valid", 64'(if_resp_valid), 64'(ex_ifv));
      check("d_resp_valid", 64'(d_resp_valid), 64'(ex_dv));
      check("if_resp_data", 64'(if_resp_data), 64'(e_if_data));
      check("d_resp_data", 64'(d_resp_data), 64'(e_d_data));
      check("if_stall", 64'(if_stall), 64'(if_req_valid && !ex_ifv));
      check("d_stall", 64'(d_stall), 64'(d_req_valid && !ex_dv));
      if (reset_n) begin
        if (busy && cyc == resp_due) begin
          busy = 0;
          if (own_d) d_act = 0;
          else f_act = 0;
        end else if (rd_pend && mem_resp_valid) begin
          rd_pend = 0;
          resp_due = cyc + 1;
          if (own_d) e_d_data = mem_resp_data;
          else e_if_data = mem_resp_data;
        end else if (req_open && mem_req_ready) begin
          req_open = 0;
          if (x_we) begin
            resp_due = cyc + 1;
            e_d_data = '0;
          end else begin
            rd_pend = 1;
            resp_at = cyc + 1 + int'($urandom_range(2));
          end
        end else if (!busy) begin
          gd = d_req_valid && !(if_req_valid && dwell == DMAX);
          if (gd || if_req_valid) begin
            busy = 1; req_open = 1; own_d = gd;
            x_addr = gd ? d_addr : if_addr;
            x_we = gd && d_req_we;
            x_mask = gd ? d_req_wmask : 4'h0;
            x_data = gd ? d_wdata : '0;
            dwell = (gd && if_req_valid) ? ((dwell + 1 > DMAX) ? DMAX : dwell + 1) : 0;
          end
        end
      end
    end
    check("fetch_wait_reset_hit", 64'(rst_done), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
